// File: rtl/ssp_stack_ptr_pkg.sv
// Shared CP0 constants for the system stack pointer register group.
// Holds enable encodings, the CP0 word width and the SSP reset value.
package ssp_stack_ptr_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int CP0_DATA_W = 32;

    typedef logic [CP0_DATA_W-1:0] cp0_word_t;

    localparam cp0_word_t SSP_RESET_VAL = 32'h0000_0000;

    // Unknown or floating enables compare false here, so they act as deasserted.
    function automatic logic is_enabled(input logic en);
        if (en == ENABLE) begin
            return ENABLE;
        end else begin
            return DISABLE;
        end
    endfunction

endpackage

// File: rtl/ssp_stack_ptr_storage_reg.sv
// WIDTH-bit register with asynchronous active-high reset and a load enable.
// Used as the storage element of the system stack pointer.
module ssp_storage_reg
    import ssp_stack_ptr_pkg::*;
#(
    parameter int               WIDTH     = CP0_DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic load;

    assign load = is_enabled(en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ssp_stack_ptr.sv
// System stack pointer holding register with gated combinational read.
// Optional write-through forwarding on simultaneous read/write: SSP_WRITE_BYPASS_EN.
module ssp_stack_ptr
    import ssp_stack_ptr_pkg::*;
#(
    parameter int               WIDTH      = CP0_DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL  = SSP_RESET_VAL,
    parameter int               ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_s,
    input  logic             re_p,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    output logic             misaligned
);

    logic [WIDTH-1:0] ptr;
    logic             rd_en;

    ssp_storage_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_storage (
        .clk (clk),
        .rst (rst),
        .en  (we_s),
        .d   (write_data),
        .q   (ptr)
    );

    assign rd_en = is_enabled(re_p);

`ifdef SSP_WRITE_BYPASS_EN
    logic fwd_en;

    assign fwd_en = is_enabled(we_s) && (rst == DISABLE);

    // Forward the incoming word so a same-cycle reader sees the value being written.
    always_comb begin
        read_data = '0;
        if (rd_en) begin
            read_data = fwd_en ? write_data : ptr;
        end
    end
`else
    always_comb begin
        read_data = '0;
        if (rd_en) begin
            read_data = ptr;
        end
    end
`endif

    // Status only: a misaligned pointer is still stored as written.
    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign misaligned = |ptr[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_ssp_stack_ptr.sv
// Self-checking bench for ssp_stack_ptr: directed scenarios plus randomized traffic
// compared against a simple register model.
module tb_ssp_stack_ptr;

    logic        clk;
    logic        rst;
    logic        we_s;
    logic        re_p;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        misaligned;

    int          checks;
    int          failures;
    logic [31:0] model_ptr;

    ssp_stack_ptr dut (
        .clk        (clk),
        .rst        (rst),
        .we_s       (we_s),
        .re_p       (re_p),
        .write_data (write_data),
        .read_data  (read_data),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_read(input logic re, input logic we, input logic r,
                                             input logic [31:0] wd, input logic [31:0] p);
        if (re !== 1'b1) return 32'h0;
`ifdef SSP_WRITE_BYPASS_EN
        if (we === 1'b1 && r === 1'b0) return wd;
`endif
        return p;
    endfunction

    function automatic logic exp_mis(input logic [31:0] p);
        return (p % 4) != 0;
    endfunction

    task automatic drive(input logic we, input logic re, input logic [31:0] wd);
        @(negedge clk);
        we_s       = we;
        re_p       = re;
        write_data = wd;
    endtask

    task automatic edge_update();
        @(posedge clk);
        if (rst === 1'b1) model_ptr = 32'h0;
        else if (we_s === 1'b1) model_ptr = write_data;
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        re_p       = 1'b1;
        we_s       = 1'bx;
        write_data = 32'hDEAD_BEEF;
        model_ptr  = 32'h0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_read got=%h exp=%h", read_data, 32'h0);
        end
        checks++;
        if (misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset_misaligned got=%b exp=0", misaligned);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL x_we_after_reset got=%h exp=%h", read_data, 32'h0);
        end
        drive(1'b0, 1'bx, 32'h1111_1111);
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL x_re_read got=%h exp=%h", read_data, 32'h0);
        end
        drive(1'b0, 1'b1, 32'h2222_2222);
        edge_update();
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL hold_after_reset got=%h exp=%h", read_data, 32'h0);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 32'h0000_000F);
        edge_update();
        drive(1'b0, 1'b1, 32'h1234_5678);
        #1;
        checks++;
        if (read_data !== 32'h0000_000F) begin
            failures++;
            $display("FAIL write_read got=%h exp=%h", read_data, 32'h0000_000F);
        end
        checks++;
        if (misaligned !== 1'b1) begin
            failures++;
            $display("FAIL write_misaligned got=%b exp=1", misaligned);
        end
        edge_update();
        checks++;
        if (read_data !== 32'h0000_000F) begin
            failures++;
            $display("FAIL write_hold got=%h exp=%h", read_data, 32'h0000_000F);
        end
    endtask

    task automatic test_read_gating();
        drive(1'b1, 1'b1, 32'h8000_1000);
        edge_update();
        drive(1'b0, 1'b1, 32'h0);
        #1;
        checks++;
        if (read_data !== 32'h8000_1000) begin
            failures++;
            $display("FAIL gate_on1 got=%h exp=%h", read_data, 32'h8000_1000);
        end
        #1 re_p = 1'b0;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL gate_off got=%h exp=%h", read_data, 32'h0);
        end
        #1 re_p = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'h8000_1000) begin
            failures++;
            $display("FAIL gate_on2 got=%h exp=%h", read_data, 32'h8000_1000);
        end
        checks++;
        if (misaligned !== 1'b0) begin
            failures++;
            $display("FAIL gate_misaligned got=%b exp=0", misaligned);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] pre_exp;
        drive(1'b1, 1'b1, 32'hA);
        edge_update();
        drive(1'b1, 1'b1, 32'hB);
        #1;
`ifdef SSP_WRITE_BYPASS_EN
        pre_exp = 32'hB;
`else
        pre_exp = 32'hA;
`endif
        checks++;
        if (read_data !== pre_exp) begin
            failures++;
            $display("FAIL simul_pre_edge got=%h exp=%h", read_data, pre_exp);
        end
        checks++;
        if (misaligned !== 1'b1) begin
            failures++;
            $display("FAIL simul_misaligned got=%b exp=1", misaligned);
        end
        edge_update();
        checks++;
        if (read_data !== 32'hB) begin
            failures++;
            $display("FAIL simul_post_edge got=%h exp=%h", read_data, 32'hB);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 32'hFFFF_FFF0);
        edge_update();
        drive(1'b0, 1'b1, 32'h0);
        #1;
        checks++;
        if (read_data !== 32'hFFFF_FFF0) begin
            failures++;
            $display("FAIL areset_preload got=%h exp=%h", read_data, 32'hFFFF_FFF0);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        model_ptr = 32'h0;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL areset_immediate got=%h exp=%h", read_data, 32'h0);
        end
        drive(1'b1, 1'b1, 32'h55);
        edge_update();
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL areset_write_ignored got=%h exp=%h", read_data, 32'h0);
        end
        @(negedge clk);
        rst  = 1'b0;
        we_s = 1'b0;
        edge_update();
        checks++;
        if (read_data !== 32'h0 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL areset_after got=%h/%b exp=%h/0", read_data, misaligned, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h100;
        vals[1] = 32'h104;
        vals[2] = 32'h108;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, vals[i]);
            edge_update();
            checks++;
            if (read_data !== vals[i] || misaligned !== 1'b0) begin
                failures++;
                $display("FAIL b2b_%0d got=%h/%b exp=%h/0", i, read_data, misaligned, vals[i]);
            end
        end
        drive(1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_random();
        logic        we;
        logic        re;
        logic [31:0] wd;
        logic [31:0] e;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 3) != 0);
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) wd[1:0] = 2'b00;
            drive(we, re, wd);
            #1;
            e = exp_read(re, we, rst, wd, model_ptr);
            checks++;
            if (read_data !== e || misaligned !== exp_mis(model_ptr)) begin
                failures++;
                $display("FAIL rand_pre_%0d got=%h/%b exp=%h/%b", n, read_data, misaligned,
                         e, exp_mis(model_ptr));
            end
            edge_update();
            we_s = 1'b0;
            #1;
            e = exp_read(re, 1'b0, rst, wd, model_ptr);
            checks++;
            if (read_data !== e || misaligned !== exp_mis(model_ptr)) begin
                failures++;
                $display("FAIL rand_post_%0d got=%h/%b exp=%h/%b", n, read_data, misaligned,
                         e, exp_mis(model_ptr));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_read_gating();
        test_simultaneous();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssp_stack_ptr.md
Name: ssp_stack_ptr

Overview:
- System Stack Pointer (SSP) holding register for the CP0 register group.
- Stores one 32-bit stack pointer value.
- Written synchronously when `we_s` is asserted; read out combinationally when `re_p` is asserted.
- Sits beside the other CP0 special registers; the exception/privilege logic reads the kernel stack pointer from it.

Parameters:
- `WIDTH`, 32, data width of the stack pointer and data ports.
- `RESET_VAL`, 32'h0000_0000, value loaded into the pointer on reset.
- `ALIGN_BITS`, 2, number of low bits that must be zero for an aligned pointer (word alignment).

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `we_s`  input  1  write-enable (set); `ENABLE`=1, `DISABLE`=0.
- `re_p`  input  1  read-enable (put); `ENABLE`=1, `DISABLE`=0.
- `write_data`  input  WIDTH  value to store into the pointer.
- `read_data`  output  WIDTH  pointer value when read-enabled, else zero.
- `misaligned`  output  1  high when stored pointer's low `ALIGN_BITS` bits are non-zero.

Behaviour:
- One clock (`clk`). Reset is asynchronous and active-high (`rst`). While `rst`=1 the pointer is held at `RESET_VAL` regardless of the clock.
- Reset values:
  - internal pointer = `RESET_VAL`;
  - `read_data` = `RESET_VAL` if `re_p`=1, else 0;
  - `misaligned` = 0 for the default `RESET_VAL`.
- Write: at rising `clk` with `rst`=0 and `we_s`=1, pointer <= `write_data`. The value is stored unmodified (no masking). One-cycle latency: the new value is visible after that edge.
- `we_s`=0: pointer holds its value.
- `we_s` or `re_p` unknown (X/Z) is treated as deasserted. The pointer must not be corrupted when `we_s` is X or Z before its first drive after reset.
- Read: combinational. `read_data` = pointer when `re_p`=1, else `read_data` = 0 (no stale data driven).
- Read and write in the same cycle: `read_data` shows the pre-edge (old) pointer until the edge, then the new one (no forwarding unless the optional feature is enabled).
- `misaligned`: combinational, = OR of pointer[`ALIGN_BITS`-1:0]. It is status only; the write is still accepted.
- Reset asserted mid-operation: the pointer returns to `RESET_VAL` immediately. A write coinciding with reset is discarded.
- No other state. No FSM.

Optional Feature:
- Macro `SSP_WRITE_BYPASS_EN`.
- Defined: when `we_s`=1 and `re_p`=1 in the same cycle (`rst`=0), `read_data` = `write_data` combinationally (write-through forwarding). `misaligned` still reflects the stored pointer.
- Undefined: `read_data` always reflects the stored pointer (old value during a simultaneous write).

Decomposition:
- Shared package/header: `ENABLE` (1'b1) and `DISABLE` (1'b0) constants, CP0 data width constant (32), and the SSP reset-value constant.
- One natural sub-module: `ssp_storage_reg`, a parameterized `WIDTH`-bit async-reset, enabled flip-flop register.
- The top block adds the read gating, the optional bypass mux and the misalignment flag.

Test Plan:
- Reset: `rst`=1 for 100 ps with `re_p`=1 -> `read_data`=0x0000_0000, `misaligned`=0. Release `rst` with `we_s`=0 -> value stays 0.
- Write/read:
  - `rst`=0, `we_s`=1, `write_data`=0x0000_000F, `re_p`=1 -> after the next rising edge `read_data`=0x0000_000F, `misaligned`=1.
  - Then `we_s`=0, `write_data`=0x1234_5678 -> `read_data` stays 0x0000_000F.
- Read gating: pointer=0x8000_1000, toggle `re_p` 1->0->1 -> `read_data` 0x8000_1000 -> 0 -> 0x8000_1000 with no clock edge needed; `misaligned`=0.
- Simultaneous read/write: pointer=0xA, `we_s`=1, `re_p`=1, `write_data`=0xB.
  - Bypass macro undefined: `read_data`=0xA before the edge, 0xB after.
  - `SSP_WRITE_BYPASS_EN` defined: `read_data`=0xB before the edge.
- Async reset mid-operation: pointer=0xFFFF_FFF0, assert `rst` between clock edges -> `read_data` drops to 0 immediately. A write of 0x55 during reset is ignored; after reset it still reads 0.
- Back-to-back writes: 0x100, 0x104, 0x108 on consecutive edges with `re_p`=1 -> `read_data` follows with one-edge latency each cycle; `misaligned` stays 0.
